reg_scoreboard: RTL and testbench



---
 rtl/reg_scoreboard_pkg.sv | 10 +
 rtl/reg_scoreboard_match.sv | 28 ++
 rtl/reg_scoreboard.sv | 98 +++++++++
 tb/tb_reg_scoreboard.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared widths, latency codes and select-width helper for the ID-stage scoreboard
package reg_scoreboard_pkg;
  localparam int REG_ADDR_BUS = 5;
  localparam int LAT_ALU = 1;
  localparam int LAT_LOAD = 2;
  localparam int FWD_NONE = 0;
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/reg_scoreboard_match.sv
// reg_scoreboard_match: youngest-match priority encoder for one source read port
module reg_scoreboard_match
  import reg_scoreboard_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_BUS,
  parameter int PIPE_DEPTH = 3,
  parameter int SEL_W = sel_w(PIPE_DEPTH)
) (
  input  logic                                read_en_i,
  input  logic [ADDR_W-1:0]                   read_addr_i,
  input  logic [PIPE_DEPTH-1:0]               ent_valid_i,
  input  logic [PIPE_DEPTH-1:0][ADDR_W-1:0]   ent_addr_i,
  input  logic [PIPE_DEPTH-1:0]               ent_ready_i,
  output logic                                stall_req_o,
  output logic [SEL_W-1:0]                    fwd_sel_o
);
  // scan oldest to youngest so the lowest-index hit overwrites older ones
  always_comb begin
    stall_req_o = 1'b0;
    fwd_sel_o = SEL_W'(FWD_NONE);
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (read_en_i && read_addr_i != '0 && ent_valid_i[k] && ent_addr_i[k] == read_addr_i) begin
        stall_req_o = ~ent_ready_i[k];
        fwd_sel_o = ent_ready_i[k] ? SEL_W'(k + 1) : SEL_W'(FWD_NONE);
      end
    end
  end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight destination registers and drives ID stall and bypass selects
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_BUS,
  parameter int REG_NUM = 2 ** ADDR_W,
  parameter int READ_PORTS = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int SEL_W = sel_w(PIPE_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [READ_PORTS-1:0]         read_en,
  input  logic [READ_PORTS*ADDR_W-1:0]  read_addr,
  input  logic                          write_en,
  input  logic [ADDR_W-1:0]             write_addr,
  input  logic [SEL_W-1:0]              write_lat,
  input  logic                          advance,
  input  logic                          flush,
  output logic                          stall,
  output logic [READ_PORTS*SEL_W-1:0]   fwd_sel,
  output logic [REG_NUM-1:0]            busy_mask
);
  logic [PIPE_DEPTH-1:0]              valid_q, valid_d;
  logic [PIPE_DEPTH-1:0][ADDR_W-1:0]  addr_q, addr_d;
  logic [PIPE_DEPTH-1:0][SEL_W-1:0]   rem_q, rem_d;
  logic [PIPE_DEPTH-1:0]              ready;
  logic [READ_PORTS-1:0]              stall_req;
  logic                               issue;
  logic [SEL_W-1:0]                   lat;

  // an entry is forwardable once its remaining latency has drained
  always_comb begin
    ready = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) ready[k] = rem_q[k] == '0;
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    reg_scoreboard_match #(
      .ADDR_W(ADDR_W),
      .PIPE_DEPTH(PIPE_DEPTH),
      .SEL_W(SEL_W)
    ) u_match (
      .read_en_i(read_en[p]),
      .read_addr_i(read_addr[p*ADDR_W +: ADDR_W]),
      .ent_valid_i(valid_q),
      .ent_addr_i(addr_q),
      .ent_ready_i(ready),
      .stall_req_o(stall_req[p]),
      .fwd_sel_o(fwd_sel[p*SEL_W +: SEL_W])
    );
  end

  assign stall = id_valid & (|stall_req);
  assign issue = id_valid & ~stall & advance & write_en & (write_addr != '0);
  assign lat = (write_lat == '0) ? SEL_W'(LAT_ALU) :
               (write_lat > SEL_W'(PIPE_DEPTH)) ? SEL_W'(PIPE_DEPTH) : write_lat;

  // flush clears everything; advance shifts entries older and drains their latency
  always_comb begin
    valid_d = valid_q;
    addr_d = addr_q;
    rem_d = rem_q;
    if (flush) begin
      valid_d = '0;
    end else if (advance) begin
      valid_d[0] = issue;
      addr_d[0] = issue ? write_addr : '0;
      rem_d[0] = issue ? lat - SEL_W'(1) : '0;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        addr_d[k] = addr_q[k-1];
        rem_d[k] = (rem_q[k-1] == '0) ? '0 : rem_q[k-1] - SEL_W'(1);
      end
    end
  end

  // entry storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
    end
  end

  // one-hot decode of every valid destination; $0 is never busy
  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) if (valid_q[k]) busy_mask[addr_q[k]] = 1'b1;
    busy_mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vector table plus reset sequence for reg_scoreboard
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [1:0]  read_en = '0;
  logic [9:0]  read_addr = '0;
  logic        write_en = 1'b0;
  logic [4:0]  write_addr = '0;
  logic [1:0]  write_lat = '0;
  logic        advance = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [31:0] busy_mask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iv;
    logic [1:0]  ren;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        we;
    logic [4:0]  wa;
    logic [1:0]  wl;
    logic        adv;
    logic        fl;
    logic        est;
    logic [1:0]  ef0;
    logic [1:0]  ef1;
    logic [31:0] eb;
  } vec_t;

  vec_t vq[$];

  reg_scoreboard dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .read_en(read_en),
    .read_addr(read_addr),
    .write_en(write_en),
    .write_addr(write_addr),
    .write_lat(write_lat),
    .advance(advance),
    .flush(flush),
    .stall(stall),
    .fwd_sel(fwd_sel),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic iv, input logic [1:0] ren, input logic [4:0] ra0,
                              input logic [4:0] ra1, input logic we, input logic [4:0] wa,
                              input logic [1:0] wl, input logic adv, input logic fl,
                              input logic est, input logic [1:0] ef0, input logic [1:0] ef1,
                              input logic [31:0] eb);
    vec_t v;
    v.iv = iv; v.ren = ren; v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa = wa; v.wl = wl;
    v.adv = adv; v.fl = fl; v.est = est; v.ef0 = ef0; v.ef1 = ef1; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    id_valid = v.iv; read_en = v.ren; read_addr = {v.ra1, v.ra0};
    write_en = v.we; write_addr = v.wa; write_lat = v.wl; advance = v.adv; flush = v.fl;
  endtask

  task automatic check_out(input string tag, input logic est, input logic [1:0] ef0,
                           input logic [1:0] ef1, input logic [31:0] eb);
    chk({tag, " stall"}, 32'(stall), 32'(est));
    chk({tag, " fwd0"}, 32'(fwd_sel[1:0]), 32'(ef0));
    chk({tag, " fwd1"}, 32'(fwd_sel[3:2]), 32'(ef1));
    chk({tag, " busy"}, busy_mask, eb);
  endtask

  initial begin
    vq.push_back(mk(0,0,0,0,  0,0,0,       1,0, 0,0,0,32'h0));
    vq.push_back(mk(1,0,0,0,  1,3,LAT_ALU, 1,0, 0,0,0,32'h0));
    vq.push_back(mk(1,1,3,0,  0,0,0,       1,0, 0,1,0,32'h8));
    vq.push_back(mk(1,1,3,0,  0,0,0,       1,0, 0,2,0,32'h8));
    vq.push_back(mk(1,1,3,0,  1,5,LAT_LOAD,1,0, 0,3,0,32'h8));
    vq.push_back(mk(1,2,0,5,  0,0,0,       1,0, 1,0,0,32'h20));
    vq.push_back(mk(1,2,0,5,  0,0,0,       1,0, 0,0,2,32'h20));
    vq.push_back(mk(1,0,0,0,  1,7,LAT_ALU, 1,0, 0,0,0,32'h20));
    vq.push_back(mk(1,0,0,0,  1,7,LAT_LOAD,1,0, 0,0,0,32'h80));
    vq.push_back(mk(1,1,7,0,  0,0,0,       1,0, 1,0,0,32'h80));
    vq.push_back(mk(1,1,7,0,  0,0,0,       1,0, 0,2,0,32'h80));
    vq.push_back(mk(1,3,0,0,  1,0,1,       1,0, 0,0,0,32'h80));
    vq.push_back(mk(1,3,0,0,  0,0,0,       1,0, 0,0,0,32'h0));
    vq.push_back(mk(1,0,0,0,  1,9,LAT_LOAD,1,0, 0,0,0,32'h0));
    for (int i = 0; i < 4; i++) vq.push_back(mk(1,1,9,0, 0,0,0, 0,0, 1,0,0,32'h200));
    vq.push_back(mk(1,1,9,0,  0,0,0,       1,0, 1,0,0,32'h200));
    vq.push_back(mk(1,1,9,0,  0,0,0,       0,0, 0,2,0,32'h200));
    vq.push_back(mk(1,0,0,0,  1,1,1,       1,0, 0,0,0,32'h200));
    vq.push_back(mk(1,0,0,0,  1,2,1,       1,0, 0,0,0,32'h202));
    vq.push_back(mk(1,0,0,0,  1,4,1,       1,0, 0,0,0,32'h6));
    vq.push_back(mk(1,0,0,0,  1,6,1,       1,1, 0,0,0,32'h16));
    vq.push_back(mk(0,0,0,0,  0,0,0,       1,0, 0,0,0,32'h0));
    vq.push_back(mk(1,0,0,0,  1,1,1,       1,0, 0,0,0,32'h0));
    vq.push_back(mk(0,0,0,0,  0,0,0,       1,0, 0,0,0,32'h2));
    vq.push_back(mk(0,0,0,0,  0,0,0,       1,0, 0,0,0,32'h2));
    vq.push_back(mk(0,0,0,0,  0,0,0,       1,0, 0,0,0,32'h2));
    vq.push_back(mk(0,0,0,0,  0,0,0,       0,0, 0,0,0,32'h0));
    vq.push_back(mk(1,0,0,0,  1,10,0,      1,0, 0,0,0,32'h0));
    vq.push_back(mk(1,2,0,10, 0,0,0,       0,0, 0,0,1,32'h400));
    vq.push_back(mk(1,2,0,10, 1,11,3,      1,0, 0,0,1,32'h400));
    vq.push_back(mk(1,3,11,10,1,12,1,      1,0, 1,0,2,32'hC00));
    vq.push_back(mk(1,3,11,12,0,0,0,       1,0, 1,0,0,32'hC00));
    vq.push_back(mk(1,1,11,0, 0,0,0,       0,0, 0,3,0,32'h800));
    vq.push_back(mk(1,0,11,0, 0,0,0,       0,0, 0,0,0,32'h800));
    vq.push_back(mk(1,0,0,0,  1,12,2,      1,0, 0,0,0,32'h800));
    vq.push_back(mk(0,1,12,0, 0,0,0,       0,0, 0,0,0,32'h1000));

    #3;
    check_out("reset", 1'b0, 2'd0, 2'd0, 32'h0);
    #4 rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      apply(vq[i]);
      #1;
      check_out($sformatf("vec%0d", i), vq[i].est, vq[i].ef0, vq[i].ef1, vq[i].eb);
    end

    @(negedge clk);
    apply(mk(1,0,0,0, 1,13,1, 1,0, 0,0,0,32'h0));
    @(negedge clk);
    apply(mk(1,0,0,0, 1,14,2, 1,0, 0,0,0,32'h0));
    @(negedge clk);
    apply(mk(1,1,14,0, 0,0,0, 0,0, 0,0,0,32'h0));
    #1;
    check_out("pre_rst", 1'b1, 2'd0, 2'd0, 32'h7000);
    #1 rst_n = 1'b0;
    #1;
    check_out("mid_rst", 1'b0, 2'd0, 2'd0, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_out("post_rst", 1'b0, 2'd0, 2'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
